// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for one router input port.
// Buffers payload bytes, then sends header {len,dest}, the payload and an
// even-XOR parity byte, stalling while the router is busy. Afterwards it
// watches the router error flag for a short window and keeps saturating
// packet and error counters.
module router_pkt_tx #(
  parameter int MAX_LEN      = 63,
  parameter int BUSY_TIMEOUT = 1023,
  parameter int ERR_WAIT     = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_pl_data,
  input  logic             i_pl_valid,
  output logic             o_pl_ready,
  input  logic             i_start,
  input  logic [1:0]       i_dest,
  output logic             o_tx_ready,
  input  logic             i_busy,
  input  logic             i_err,
  output logic             o_pkt_valid,
  output logic [7:0]       o_data_out,
  output logic             o_tx_done,
  output logic             o_tx_reject,
  output logic             o_tx_abort,
  output logic [CNT_W-1:0] o_pkt_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PLD, S_PAR, S_EWAIT} state_t;

  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam int EW = $clog2(ERR_WAIT + 1);
  localparam logic [5:0]       LEN_MAX = 6'(MAX_LEN);
  localparam logic [BW-1:0]    TO_LAST = BW'(BUSY_TIMEOUT - 1);
  localparam logic [EW-1:0]    EW_LAST = EW'(ERR_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state, w_state;
  logic [7:0]       r_buf [MAX_LEN];
  logic [5:0]       r_count, w_count;
  logic [5:0]       r_rptr, w_rptr;
  logic [5:0]       r_len, w_len;
  logic [7:0]       r_parity, w_parity;
  logic             r_pkt_valid, w_pkt_valid;
  logic [7:0]       r_data_out, w_data_out;
  logic             r_tx_done, w_tx_done;
  logic             r_tx_reject, w_tx_reject;
  logic             r_tx_abort, w_tx_abort;
  logic [CNT_W-1:0] r_pkt_cnt, w_pkt_cnt;
  logic [CNT_W-1:0] r_err_cnt, w_err_cnt;
  logic [BW-1:0]    r_bcnt, w_bcnt;
  logic [EW-1:0]    r_ecnt, w_ecnt;
  logic             r_err_flag, w_err_flag;

  logic             w_send_st;
  logic             w_accept;
  logic             w_busy_to;
  logic             w_write;
  logic [7:0]       w_rd_byte;

  // Buffer may accept only while idle, not launching, not full, and out of reset.
  assign o_pl_ready = (r_state == S_IDLE) & ~i_start & (r_count < LEN_MAX) & rst;
  assign o_tx_ready = (r_state == S_IDLE);
  assign w_write    = i_pl_valid & o_pl_ready;
  assign w_send_st  = (r_state == S_HDR) | (r_state == S_PLD) | (r_state == S_PAR);
  assign w_accept   = w_send_st & ~i_busy;
  assign w_busy_to  = w_send_st & i_busy & (r_bcnt == TO_LAST);
  assign w_rd_byte  = r_buf[r_rptr];

  assign o_pkt_valid = r_pkt_valid;
  assign o_data_out  = r_data_out;
  assign o_tx_done   = r_tx_done;
  assign o_tx_reject = r_tx_reject;
  assign o_tx_abort  = r_tx_abort;
  assign o_pkt_cnt   = r_pkt_cnt;
  assign o_err_cnt   = r_err_cnt;

  // Payload buffer write port, filled in arrival order at the current count.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_buf[r_count] <= i_pl_data;
    end
  end

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    w_state     = r_state;
    w_count     = r_count;
    w_rptr      = r_rptr;
    w_len       = r_len;
    w_parity    = r_parity;
    w_pkt_valid = r_pkt_valid;
    w_data_out  = r_data_out;
    w_tx_done   = 1'b0;
    w_tx_reject = 1'b0;
    w_tx_abort  = 1'b0;
    w_pkt_cnt   = r_pkt_cnt;
    w_err_cnt   = r_err_cnt;
    w_ecnt      = r_ecnt;
    w_err_flag  = r_err_flag;
    // Consecutive busy cycles are only meaningful while a byte is offered.
    if (w_send_st && i_busy) begin
      w_bcnt = r_bcnt + 1'b1;
    end else begin
      w_bcnt = '0;
    end

    if (w_busy_to) begin
      // Router stuck busy: give up on this packet without touching counters.
      w_state     = S_IDLE;
      w_pkt_valid = 1'b0;
      w_data_out  = 8'h00;
      w_tx_abort  = 1'b1;
      w_count     = 6'd0;
      w_bcnt      = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if ((r_count == 6'd0) || (i_dest == 2'd3)) begin
              w_tx_reject = 1'b1;
            end else begin
              w_state     = S_HDR;
              w_data_out  = {r_count, i_dest};
              w_parity    = {r_count, i_dest};
              w_pkt_valid = 1'b1;
              w_len       = r_count;
              w_rptr      = 6'd0;
            end
          end else if (w_write) begin
            w_count = r_count + 6'd1;
          end else begin
            w_count = r_count;
          end
        end
        S_HDR, S_PLD: begin
          if (!w_accept) begin
            w_state = r_state;
          end else if ((r_state == S_HDR) || (r_rptr < r_len)) begin
            // Parity already includes every byte placed on data_out.
            w_state    = S_PLD;
            w_data_out = w_rd_byte;
            w_parity   = r_parity ^ w_rd_byte;
            w_rptr     = r_rptr + 6'd1;
          end else begin
            w_state     = S_PAR;
            w_pkt_valid = 1'b0;
            w_data_out  = r_parity;
          end
        end
        S_PAR: begin
          if (w_accept) begin
            w_state    = S_EWAIT;
            w_data_out = 8'h00;
            w_ecnt     = '0;
            w_err_flag = 1'b0;
          end else begin
            w_state = S_PAR;
          end
        end
        S_EWAIT: begin
          if (r_ecnt == EW_LAST) begin
            w_state   = S_IDLE;
            w_tx_done = 1'b1;
            w_count   = 6'd0;
            if (r_pkt_cnt != CNT_MAX) begin
              w_pkt_cnt = r_pkt_cnt + 1'b1;
            end else begin
              w_pkt_cnt = r_pkt_cnt;
            end
            if ((r_err_flag | i_err) && (r_err_cnt != CNT_MAX)) begin
              w_err_cnt = r_err_cnt + 1'b1;
            end else begin
              w_err_cnt = r_err_cnt;
            end
          end else begin
            w_ecnt     = r_ecnt + 1'b1;
            w_err_flag = r_err_flag | i_err;
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_count     <= 6'd0;
      r_rptr      <= 6'd0;
      r_len       <= 6'd0;
      r_parity    <= 8'h00;
      r_pkt_valid <= 1'b0;
      r_data_out  <= 8'h00;
      r_tx_done   <= 1'b0;
      r_tx_reject <= 1'b0;
      r_tx_abort  <= 1'b0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
      r_bcnt      <= '0;
      r_ecnt      <= '0;
      r_err_flag  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_count     <= w_count;
      r_rptr      <= w_rptr;
      r_len       <= w_len;
      r_parity    <= w_parity;
      r_pkt_valid <= w_pkt_valid;
      r_data_out  <= w_data_out;
      r_tx_done   <= w_tx_done;
      r_tx_reject <= w_tx_reject;
      r_tx_abort  <= w_tx_abort;
      r_pkt_cnt   <= w_pkt_cnt;
      r_err_cnt   <= w_err_cnt;
      r_bcnt      <= w_bcnt;
      r_ecnt      <= w_ecnt;
      r_err_flag  <= w_err_flag;
    end
  end

endmodule
